// File: rtl/score_recorder.sv
// Live key capture: run-length encodes one voice's key code into (note, duration)
// entries on each score tick and stores them in a dual-port RAM with a read port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no recording since reset
// S_WAIT  | armed, skipping leading silence until the first key
// S_REC   | accumulating the current segment, committing on change
// S_FLUSH | commit the open segment after stop
// S_TERM  | write the {0,0} terminator at wr_ptr
// S_DONE  | recording finished, entries readable
module score_recorder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int TICK_DIV   = 14
) (
    input  logic                  clk,
    input  logic                  grst,
    input  logic [6:0]            key_in,
    input  logic                  arm,
    input  logic                  stop,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [6:0]            rd_note,
    output logic [15:0]           rd_dur,
    output logic [DEPTH_LOG2-1:0] count,
    output logic                  recording,
    output logic                  done,
    output logic                  full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REC,
        S_FLUSH,
        S_TERM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    full_q, full_d;
    logic [6:0]              cur_note_q, cur_note_d;
    logic [15:0]             cur_dur_q, cur_dur_d;
    logic                    recording_q, recording_d;
    logic                    done_q, done_d;
    logic [6:0]              rd_note_q;
    logic [15:0]             rd_dur_q;

    logic                    tick;
    logic                    presc_clr;
    logic                    wr_en;
    logic [22:0]             wr_data;
    logic                    last_slot;

    logic [22:0]             mem [2**DEPTH_LOG2];

    generate
        if (TICK_DIV == 0) begin : g_tick_every_clk
            assign tick = 1'b1;
        end else begin : g_presc
            logic [TICK_DIV-1:0] presc_q, presc_d;

            always_comb begin
                presc_d = presc_q + 1'b1;
                if (presc_clr) presc_d = '0;
            end

            always_ff @(posedge clk) begin
                if (grst) presc_q <= '0;
                else      presc_q <= presc_d;
            end

            assign tick = &presc_q;
        end
    endgenerate

    // The top slot is reserved for the terminator, so no segment may land there.
    assign last_slot = &wr_ptr_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q;
        cur_note_d = cur_note_q;
        cur_dur_d  = cur_dur_q;
        presc_clr  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = {cur_note_q, cur_dur_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d   = S_WAIT;
                    wr_ptr_d  = '0;
                    full_d    = 1'b0;
                    presc_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_TERM;
                end else if (tick && key_in != 7'd0) begin
                    state_d    = S_REC;
                    cur_note_d = key_in;
                    cur_dur_d  = 16'd1;
                end
            end
            S_REC: begin
                if (stop) begin
                    state_d = S_FLUSH;
                end else if (tick) begin
                    if (key_in == cur_note_q && cur_dur_q != 16'hFFFF) begin
                        cur_dur_d = cur_dur_q + 16'd1;
                    end else if (!last_slot) begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        cur_note_d = key_in;
                        cur_dur_d  = 16'd1;
                    end else begin
                        full_d  = 1'b1;
                        state_d = S_TERM;
                    end
                end
            end
            S_FLUSH: begin
                if (!last_slot) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    full_d = 1'b1;
                end
                state_d = S_TERM;
            end
            S_TERM: begin
                wr_en   = 1'b1;
                wr_data = '0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        recording_d = (state_q == S_WAIT) || (state_q == S_REC);
        done_d      = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            full_q      <= 1'b0;
            cur_note_q  <= '0;
            cur_dur_q   <= '0;
            recording_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            cur_note_q  <= cur_note_d;
            cur_dur_q   <= cur_dur_d;
            recording_q <= recording_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !grst) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            rd_note_q <= '0;
            rd_dur_q  <= '0;
        end else begin
            rd_note_q <= mem[rd_addr][22:16];
            rd_dur_q  <= mem[rd_addr][15:0];
        end
    end

    // Every write advances the pointer except the terminator, so it doubles as the count.
    assign count     = wr_ptr_q;
    assign full      = full_q;
    assign recording = recording_q;
    assign done      = done_q;
    assign rd_note   = rd_note_q;
    assign rd_dur    = rd_dur_q;

endmodule

// File: tb/tb_score_recorder.sv
// Directed bench for score_recorder: expected entries are queued while stimulus is
// driven and compared when read back through the registered read port.
module tb_score_recorder;

    localparam int DL = 3;

    typedef struct packed {
        logic [6:0]  note;
        logic [15:0] dur;
    } entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          grst;
    logic [6:0]    key_in, s_key;
    logic          arm, stop, s_arm, s_stop;
    logic [DL-1:0] rd_addr, s_rd_addr;
    logic [6:0]    rd_note, s_rd_note;
    logic [15:0]   rd_dur, s_rd_dur;
    logic [DL-1:0] count, s_count;
    logic          recording, done, full;
    logic          s_recording, s_done, s_full;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t exp_q[$];

    score_recorder #(.DEPTH_LOG2(DL), .TICK_DIV(2)) dut (
        .clk(clk), .grst(grst), .key_in(key_in), .arm(arm), .stop(stop),
        .rd_addr(rd_addr), .rd_note(rd_note), .rd_dur(rd_dur), .count(count),
        .recording(recording), .done(done), .full(full)
    );

    score_recorder #(.DEPTH_LOG2(DL), .TICK_DIV(0)) dut_sat (
        .clk(clk), .grst(grst), .key_in(s_key), .arm(s_arm), .stop(s_stop),
        .rd_addr(s_rd_addr), .rd_note(s_rd_note), .rd_dur(s_rd_dur), .count(s_count),
        .recording(s_recording), .done(s_done), .full(s_full)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input logic [6:0] k, input int n);
        key_in = k;
        step(4 * n);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int k = 0;
        while ((sel ? s_done : done) !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, sel ? s_done : done}, 32'd1);
    endtask

    task automatic push(input logic [6:0] n, input logic [15:0] d);
        entry_t e;
        e.note = n;
        e.dur  = d;
        exp_q.push_back(e);
    endtask

    task automatic read_entries(input bit sel, input int n);
        entry_t e, prev;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
                return;
            end
            e = exp_q.pop_front();
            if (sel) s_rd_addr = i[DL-1:0];
            else     rd_addr   = i[DL-1:0];
            if (i > 0) begin
                #1;
                check($sformatf("rd_hold[%0d]", i),
                      {9'd0, sel ? {s_rd_note, s_rd_dur} : {rd_note, rd_dur}}, {9'd0, prev});
            end
            step(1);
            check($sformatf("rd_note[%0d]", i), {25'd0, sel ? s_rd_note : rd_note}, {25'd0, e.note});
            check($sformatf("rd_dur[%0d]", i), {16'd0, sel ? s_rd_dur : rd_dur}, {16'd0, e.dur});
            prev = e;
        end
    endtask

    initial begin
        grst = 1'b1; key_in = '0; arm = 1'b0; stop = 1'b0; rd_addr = '0;
        s_key = '0; s_arm = 1'b0; s_stop = 1'b0; s_rd_addr = '0;
        step(2);
        check("rst_rd_note", {25'd0, rd_note}, 32'd0);
        check("rst_rd_dur", {16'd0, rd_dur}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_recording", {31'd0, recording}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_s_count", {29'd0, s_count}, 32'd0);
        grst = 1'b0;

        // idle ignores stop and keys
        stop = 1'b1; key_in = 7'h7F; step(3);
        stop = 1'b0; key_in = 7'h10; step(6);
        check("idle_recording", {31'd0, recording}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_count", {29'd0, count}, 32'd0);

        // basic capture
        do_arm();
        ticks(7'h00, 2);
        check("basic_recording", {31'd0, recording}, 32'd1);
        ticks(7'h3C, 3);
        ticks(7'h00, 2);
        ticks(7'h40, 1);
        do_stop();
        wait_done(1'b0, "basic_done");
        check("basic_count", {29'd0, count}, 32'd3);
        check("basic_full", {31'd0, full}, 32'd0);
        push(7'h3C, 16'd3); push(7'h00, 16'd2); push(7'h40, 16'd1); push(7'h00, 16'd0);
        read_entries(1'b0, 4);

        // stop coincident with a tick discards that sample
        do_arm();
        ticks(7'h50, 2);
        key_in = 7'h50;
        step(3);
        do_stop();
        wait_done(1'b0, "stoptick_done");
        check("stoptick_count", {29'd0, count}, 32'd1);
        push(7'h50, 16'd2); push(7'h00, 16'd0);
        read_entries(1'b0, 2);

        // arm during REC is ignored
        do_arm();
        ticks(7'h22, 1);
        arm = 1'b1; key_in = 7'h22; step(1);
        arm = 1'b0; step(3);
        check("armrec_recording", {31'd0, recording}, 32'd1);
        ticks(7'h23, 1);
        do_stop();
        wait_done(1'b0, "armrec_done");
        check("armrec_count", {29'd0, count}, 32'd2);
        push(7'h22, 16'd2); push(7'h23, 16'd1); push(7'h00, 16'd0);
        read_entries(1'b0, 3);

        // stop in WAIT writes only the terminator
        do_arm();
        step(2);
        do_stop();
        wait_done(1'b0, "waitstop_done");
        check("waitstop_count", {29'd0, count}, 32'd0);
        check("waitstop_full", {31'd0, full}, 32'd0);
        push(7'h00, 16'd0);
        read_entries(1'b0, 1);

        // fill the RAM
        do_arm();
        for (int i = 0; i < 10; i++) ticks((i % 2) ? 7'h31 : 7'h30, 1);
        wait_done(1'b0, "full_done");
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_count", {29'd0, count}, 32'd7);
        check("full_recording", {31'd0, recording}, 32'd0);
        for (int i = 0; i < 7; i++) push((i % 2) ? 7'h31 : 7'h30, 16'd1);
        push(7'h00, 16'd0);
        read_entries(1'b0, 8);

        // reset mid-record
        do_arm();
        ticks(7'h11, 3);
        ticks(7'h12, 2);
        check("mid_count", {29'd0, count}, 32'd1);
        check("mid_recording", {31'd0, recording}, 32'd1);
        grst = 1'b1;
        step(1);
        check("midrst_rd_note", {25'd0, rd_note}, 32'd0);
        check("midrst_rd_dur", {16'd0, rd_dur}, 32'd0);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_recording", {31'd0, recording}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_full", {31'd0, full}, 32'd0);
        grst = 1'b0;
        key_in = 7'h13;
        step(8);
        check("midrst_idle", {31'd0, recording}, 32'd0);

        // re-arm and read back
        do_arm();
        ticks(7'h00, 1);
        ticks(7'h48, 2);
        ticks(7'h4A, 1);
        ticks(7'h00, 1);
        ticks(7'h4C, 3);
        do_stop();
        wait_done(1'b0, "rearm_done");
        check("rearm_count", {29'd0, count}, 32'd4);
        push(7'h48, 16'd2); push(7'h4A, 16'd1); push(7'h00, 16'd1); push(7'h4C, 16'd3);
        push(7'h00, 16'd0);
        read_entries(1'b0, 5);

        // saturation on the tick-every-clock instance
        s_arm = 1'b1; step(1);
        s_arm = 1'b0; s_key = 7'h45;
        step(65537);
        s_stop = 1'b1; step(1);
        s_stop = 1'b0;
        wait_done(1'b1, "sat_done");
        check("sat_count", {29'd0, s_count}, 32'd2);
        check("sat_full", {31'd0, s_full}, 32'd0);
        push(7'h45, 16'hFFFF); push(7'h45, 16'd2); push(7'h00, 16'd0);
        read_entries(1'b1, 3);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
